mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit downstream of the register file. Consumes the two read-data words DR1/DR2 as operands and produces a 64-bit result in dedicated HI/LO registers. Supports MULT, MULTU, DIV and DIVU. A start/busy/done handshake lets the control unit stall the datapath while the operation runs.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  operand A (multiplicand / dividend), from register file DR1
b  input  WIDTH  operand B (multiplier / divisor), from register file DR2
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
hi  output  WIDTH  MULT: upper product; DIV: remainder
lo  output  WIDTH  MULT: lower product; DIV: quotient
div_by_zero  output  1  last completed divide had b==0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; internal counter and operand registers cleared. Reset mid-operation aborts it: no done pulse, HI/LO are 0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: on an edge with start=1, latch op, a and b. For signed ops, latch magnitudes plus sign flags. Load counter with WIDTH-1; go to CALC; busy=1 from that edge.
- CALC: one iteration per cycle, WIDTH cycles total; leaves when counter==0.
  - Multiply: shift-add on unsigned magnitudes; 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract on unsigned magnitudes.
- FIX: one cycle. Apply sign correction, then write hi/lo.
  - Signed product is negated when the operand signs differ.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - On the same edge: busy drops, done goes high for exactly one cycle, state returns to IDLE.
- Latency: start sampled at edge E0; hi/lo valid and done=1 after edge E(WIDTH+1). That is 33 edges for WIDTH=32. busy is high from E0 to E(WIDTH+1).
- start while busy: ignored; no queuing. start in the same cycle as done: accepted, since state is IDLE at that edge.
- Operands: a/b/op are used only at the start edge; later changes have no effect.
- Divide by zero: same latency. Results are lo = all ones, hi = a (original dividend), div_by_zero=1.
- div_by_zero is cleared on the next accepted start; unchanged by multiplies until then.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0.
- hi/lo hold their value between operations. They change only at FIX (or via the optional write port).

Optional Feature:
MDU_HILO_WRITE_EN
- Defined: adds ports hi_we (input, 1), lo_we (input, 1) and wdata (input, WIDTH), implementing MTHI/MTLO.
  - In IDLE with start=0, hi_we/lo_we load wdata into hi/lo on the clock edge.
  - Writes while busy are ignored.
  - start and a write in the same IDLE cycle: start wins; the write is dropped.
- Not defined: these ports do not exist; hi/lo are written only by completed operations.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly 33 edges after the start edge; busy high throughout.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21). Then DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1. A following MULTU 2*3 keeps div_by_zero=0 after its start and gives lo=6.
- Start MULTU 5*5; pulse start again at cycle 4 with a=9 -> ignored, result lo=25. New start, then rst_n=0 at cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse.
- With MDU_HILO_WRITE_EN: lo_we=1, wdata=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle. hi_we during busy -> hi unchanged.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: MULTU/MULT (shift-add) and DIVU/DIV (restoring), results in HI/LO.
// Optional MTHI/MTLO write port enabled by defining MDU_HILO_WRITE_EN.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   // state | meaning
   // IDLE  | waiting for start; hi/lo hold last result
   // CALC  | one shift-add / shift-subtract iteration per cycle
   // FIX   | sign correction, write hi/lo, pulse done
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

   state_t               state, state_nx;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opnd;
   logic [WIDTH-1:0]     a_raw;
   logic                 is_div, b_zero, neg_q, neg_r;

   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH-1:0]     rem_sh, div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   mul_next, div_next, acc_neg;
   logic [WIDTH-1:0]     quot, rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   assign a_neg = op[0] & a[WIDTH-1];
   assign b_neg = op[0] & b[WIDTH-1];
   assign a_mag = a_neg ? (~a + ONE_W) : a;
   assign b_mag = b_neg ? (~b + ONE_W) : b;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // The shifted remainder is WIDTH+1 bits; its top bit alone guarantees it exceeds the divisor,
   // and the true difference always fits WIDTH bits, so modular subtraction is exact.
   assign rem_sh   = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
   assign div_ge   = acc[2*WIDTH-1] | (rem_sh >= opnd);
   assign div_diff = rem_sh - opnd;
   assign div_next = {(div_ge ? div_diff : rem_sh), acc[WIDTH-2:0], div_ge};

   assign acc_neg = ~acc + ONE_2W;
   assign quot    = acc[WIDTH-1:0];
   assign rem     = acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         acc         <= '0;
         opnd        <= '0;
         a_raw       <= '0;
         is_div      <= 1'b0;
         b_zero      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div      <= op[1];
                  a_raw       <= a;
                  b_zero      <= (b == '0);
                  cnt         <= CNT_INIT;
                  div_by_zero <= 1'b0;
                  neg_q       <= a_neg ^ b_neg;
                  neg_r       <= a_neg;
                  if (op[1]) begin
                     acc  <= {{WIDTH{1'b0}}, a_mag};
                     opnd <= b_mag;
                  end else begin
                     acc  <= {{WIDTH{1'b0}}, b_mag};
                     opnd <= a_mag;
                  end
               end
`ifdef MDU_HILO_WRITE_EN
               else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
`endif
            end
            CALC: begin
               cnt <= cnt - CNT_ONE;
               acc <= is_div ? div_next : mul_next;
            end
            FIX: begin
               done <= 1'b1;
               if (is_div) begin
                  if (b_zero) begin
                     lo          <= '1;
                     hi          <= a_raw;
                     div_by_zero <= 1'b1;
                  end else begin
                     lo <= neg_q ? (~quot + ONE_W) : quot;
                     hi <= neg_r ? (~rem + ONE_W) : rem;
                  end
               end else begin
                  {hi, lo} <= neg_q ? acc_neg : acc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
`ifdef MDU_HILO_WRITE_EN
   logic         hi_we = 1'b0;
   logic         lo_we = 1'b0;
   logic [W-1:0] wdata = '0;
`endif
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
`ifdef MDU_HILO_WRITE_EN
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
`endif
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Drives one start pulse; returns at the falling edge after the accepting edge (E0).
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts rising edges after E0 until done is seen (bounded); notes whether busy stayed high before it.
   task automatic wait_done(output int edges, output bit ok, output bit busy_ok);
      ok = 1'b0; busy_ok = 1'b1; edges = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         edges++;
         if (done) begin ok = 1'b1; break; end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h want=0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h want=0", lo); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
   endtask

   task automatic test_multu_latency;
      int e; bit ok, bok;
      start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL multu_busy_e0 got=%b want=1", busy); end
      wait_done(e, ok, bok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL multu_timeout got=no_done want=done"); end
      n_cmp++; if (e !== 33) begin n_err++; $display("FAIL multu_latency got=%0d want=33", e); end
      n_cmp++; if (!bok) begin n_err++; $display("FAIL multu_busy_hold got=dropped want=high"); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_end got=%b want=0", busy); end
      n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
      n_cmp++; if (lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo got=%h want=00000001", lo); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_width got=%b want=0", done); end
   endtask

   task automatic test_mult_divu;
      int e; bit ok, bok;
      start_op(2'b01, 32'hFFFFFFFD, 32'd7);
      wait_done(e, ok, bok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL mult_timeout got=no_done want=done"); end
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
      start_op(2'b10, 32'd100, 32'd7);
      wait_done(e, ok, bok);
      n_cmp++; if (lo !== 32'h0000000E) begin n_err++; $display("FAIL divu_lo got=%h want=0000000e", lo); end
      n_cmp++; if (hi !== 32'h00000002) begin n_err++; $display("FAIL divu_hi got=%h want=00000002", hi); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL divu_dbz got=%b want=0", div_by_zero); end
   endtask

   task automatic test_div_signed_back_to_back;
      int e; bit ok, bok;
      start_op(2'b11, 32'hFFFFFFF9, 32'd2);
      wait_done(e, ok, bok);
      n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_lo got=%h want=fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_hi got=%h want=ffffffff", hi); end
      // start raised while done is high: accepted at the next edge
      op = 2'b11; a = 32'h80000000; b = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b want=1", busy); end
      wait_done(e, ok, bok);
      n_cmp++; if (e !== 33) begin n_err++; $display("FAIL b2b_latency got=%0d want=33", e); end
      n_cmp++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo got=%h want=80000000", lo); end
      n_cmp++; if (hi !== 32'h00000000) begin n_err++; $display("FAIL div_ovf_hi got=%h want=00000000", hi); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL div_ovf_dbz got=%b want=0", div_by_zero); end
   endtask

   task automatic test_div_by_zero;
      int e; bit ok, bok;
      start_op(2'b10, 32'h12345678, 32'h0);
      wait_done(e, ok, bok);
      n_cmp++; if (e !== 33) begin n_err++; $display("FAIL dbz_latency got=%0d want=33", e); end
      n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dbz_lo got=%h want=ffffffff", lo); end
      n_cmp++; if (hi !== 32'h12345678) begin n_err++; $display("FAIL dbz_hi got=%h want=12345678", hi); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag got=%b want=1", div_by_zero); end
      start_op(2'b00, 32'd2, 32'd3);
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_clear got=%b want=0", div_by_zero); end
      wait_done(e, ok, bok);
      n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL mul_after_dbz_lo got=%h want=00000006", lo); end
      n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL mul_after_dbz_hi got=%h want=00000000", hi); end
   endtask

   task automatic test_ignore_start;
      int e; bit ok, bok;
      start_op(2'b00, 32'd5, 32'd5);
      repeat (3) @(negedge clk);
      a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(e, ok, bok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL ignore_timeout got=no_done want=done"); end
      n_cmp++; if (lo !== 32'd25) begin n_err++; $display("FAIL ignore_lo got=%0d want=25", lo); end
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_requeue got=%b want=0", busy); end
   endtask

`ifdef MDU_HILO_WRITE_EN
   task automatic test_hilo_write;
      int e; bit ok, bok;
      logic [W-1:0] hi_before;
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'hDEADBEEF;
      @(negedge clk);
      lo_we = 1'b0;
      n_cmp++; if (lo !== 32'hDEADBEEF) begin n_err++; $display("FAIL mtlo got=%h want=deadbeef", lo); end
      hi_before = hi;
      start_op(2'b00, 32'd1, 32'd1);
      hi_we = 1'b1; wdata = 32'h11111111;
      @(negedge clk);
      hi_we = 1'b0;
      n_cmp++; if (hi !== hi_before) begin n_err++; $display("FAIL mthi_busy got=%h want=%h", hi, hi_before); end
      wait_done(e, ok, bok);
      n_cmp++; if (lo !== 32'd1) begin n_err++; $display("FAIL mthi_op_lo got=%h want=00000001", lo); end
   endtask
`endif

   task automatic test_reset_abort;
      bit seen_done;
      start_op(2'b00, 32'd1000, 32'd1000);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", busy); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL abort_hi got=%h want=0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL abort_lo got=%h want=0", lo); end
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%b want=0", seen_done); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      test_multu_latency;
      test_mult_divu;
      test_div_signed_back_to_back;
      test_div_by_zero;
      test_ignore_start;
`ifdef MDU_HILO_WRITE_EN
      test_hilo_write;
`endif
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
